// File: rtl/des_pkg.sv
// Shared DES key-handling constants: permutation tables, rotation schedule,
// schedule FSM encoding and key/subkey geometry.
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int SUBKEY_W = 48;
    localparam int HALF_W   = 28;
    localparam int ROUNDS   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_PRESENT = 2'd2,
        ST_FINISH  = 2'd3
    } ks_state_e;

    // Table entries use DES bit numbering: bit 1 is the MSB of the source word.
    localparam int unsigned PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_TAB [ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0] s);
        return (s == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0] s);
        return (s == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-entry side and subkey-consumer side of the DES key schedule.
interface des_key_schedule_if;
    import des_pkg::*;

    logic [KEY_W-1:0]    key;
    logic                start;
    logic                decrypt;
    logic [SUBKEY_W-1:0] subkey;
    logic                subkey_valid;
    logic                subkey_ready;
    logic [3:0]          round;
    logic                busy;
    logic                done;

    modport master (
        output key, start, decrypt, subkey_ready,
        input  subkey, subkey_valid, round, busy, done
    );

    modport slave (
        input  key, start, decrypt, subkey_ready,
        output subkey, subkey_valid, round, busy, done
    );

endinterface

// File: rtl/des_key_perm.sv
// Combinational DES key permutations: PC-1 (64 -> 56) and PC-2 (56 -> 48).
module des_key_perm
    import des_pkg::*;
(
    input  logic [KEY_W-1:0]    key_i,
    input  logic [CD_W-1:0]     cd_i,
    output logic [CD_W-1:0]     cd0_o,
    output logic [SUBKEY_W-1:0] subkey_o
);

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] o;
        o = '0;
        for (int i = 0; i < CD_W; i++) begin
            o[6'(CD_W - 1 - i)] = k[6'(KEY_W - PC1_TAB[i])];
        end
        return o;
    endfunction

    function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUBKEY_W-1:0] o;
        o = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            o[6'(SUBKEY_W - 1 - i)] = cd[6'(CD_W - PC2_TAB[i])];
        end
        return o;
    endfunction

    assign cd0_o    = pc1(key_i);
    assign subkey_o = pc2(cd_i);

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: emits K1..K16 (or K16..K1) one subkey per
// handshake beat, recomputing C/D in place between beats.
module des_key_schedule
    import des_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    des_key_schedule_if.slave bus
);

    ks_state_e           state_q;
    logic [HALF_W-1:0]   c_q, d_q, c_d, d_d;
    logic [3:0]          r_q;
    logic                dir_q;
    logic                valid_q, busy_q, done_q;
    logic [3:0]          round_q;
    logic [CD_W-1:0]     cd0;
    logic [SUBKEY_W-1:0] subkey;
    logic [3:0]          sidx;
    logic [1:0]          shift;

    des_key_perm u_perm (
        .key_i    (bus.key),
        .cd_i     ({c_q, d_q}),
        .cd0_o    (cd0),
        .subkey_o (subkey)
    );

    // Decrypt undoes the shift that produced the subkey just emitted: s(17-r).
    assign sidx  = dir_q ? 4'(5'd16 - {1'b0, r_q}) : r_q;
    assign shift = SHIFT_TAB[sidx];

    always_comb begin
        c_d = c_q;
        d_d = d_q;
        if (!dir_q) begin
            c_d = rotl28(c_q, shift);
            d_d = rotl28(d_q, shift);
        end else if (r_q != 4'd0) begin
            c_d = rotr28(c_q, shift);
            d_d = rotr28(d_q, shift);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            round_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        c_q     <= cd0[CD_W-1:HALF_W];
                        d_q     <= cd0[HALF_W-1:0];
                        r_q     <= '0;
                        dir_q   <= bus.decrypt;
                        busy_q  <= 1'b1;
                        state_q <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    c_q     <= c_d;
                    d_q     <= d_d;
                    round_q <= dir_q ? 4'd15 - r_q : r_q;
                    valid_q <= 1'b1;
                    state_q <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (bus.subkey_ready) begin
                        valid_q <= 1'b0;
                        if (r_q == 4'd15) begin
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end else begin
                            r_q     <= r_q + 4'd1;
                            state_q <= ST_COMPUTE;
                        end
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.subkey       = subkey;
    assign bus.subkey_valid = valid_q;
    assign bus.round        = round_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule using the classic 133457799BBCDFF1 key vectors.
module tb_des_key_schedule;
    import des_pkg::*;

    typedef struct packed {
        logic [3:0]  rnd;
        logic [47:0] sk;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_key_schedule_if bus ();

    des_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [63:0] TKEY = 64'h133457799BBCDFF1;

    // K1..K16 for TKEY.
    logic [47:0] enc_tab [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    beat_t exp_q [$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    beat_cnt = 0;
    int    done_cnt = 0;
    int    first_vld_cyc = -1;
    int    done_cyc = -1;
    int    start_cyc = 0;
    bit    rdy_random = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.subkey_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.subkey_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat, checks stalls hold.
    initial begin
        logic        stall_prev;
        logic [47:0] held_sk;
        logic [3:0]  held_rnd;
        beat_t       e;
        stall_prev = 1'b0;
        held_sk    = '0;
        held_rnd   = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 64'(bus.subkey_valid), 64'd1);
                    check("stall_subkey", 64'(bus.subkey), 64'(held_sk));
                    check("stall_round", 64'(bus.round), 64'(held_rnd));
                end
                stall_prev = 1'b0;
                if (bus.subkey_valid) begin
                    if (first_vld_cyc < 0) first_vld_cyc = cyc;
                    if (bus.subkey_ready) begin
                        beat_cnt++;
                        if (exp_q.size() == 0) begin
                            fail_now("unexpected_beat");
                        end else begin
                            e = exp_q.pop_front();
                            check("beat_round", 64'(bus.round), 64'(e.rnd));
                            check("beat_subkey", 64'(bus.subkey), 64'(e.sk));
                        end
                    end else begin
                        stall_prev = 1'b1;
                        held_sk    = bus.subkey;
                        held_rnd   = bus.round;
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
            end
        end
    end

    task automatic push_enc();
        for (int i = 0; i < 16; i++) exp_q.push_back('{rnd: 4'(i), sk: enc_tab[i]});
    endtask

    task automatic push_dec();
        for (int i = 15; i >= 0; i--) exp_q.push_back('{rnd: 4'(i), sk: enc_tab[i]});
    endtask

    task automatic push_const(input logic [47:0] v);
        for (int i = 0; i < 16; i++) exp_q.push_back('{rnd: 4'(i), sk: v});
    endtask

    task automatic launch(input logic [63:0] k, input bit dec, input bit stall);
        beat_cnt      = 0;
        done_cnt      = 0;
        first_vld_cyc = -1;
        done_cyc      = -1;
        rdy_random    = stall;
        @(posedge clk);
        #2;
        bus.key     = k;
        bus.decrypt = dec;
        bus.start   = 1'b1;
        @(posedge clk);
        #2;
        start_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [63:0] k, input bit dec,
                       input bit stall, input bit disturb, input bit chk_lat);
        int n;
        launch(k, dec, stall);
        if (disturb) begin
            bus.key     = ~k;
            bus.decrypt = ~dec;
            repeat (9) @(posedge clk);
            #2;
            bus.start = 1'b1;
            @(posedge clk);
            #2;
            bus.start = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) fail_now({tag, "_done_timeout"});
        repeat (3) @(posedge clk);
        #2;
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_beat_count"}, 64'(beat_cnt), 64'd16);
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        if (chk_lat) begin
            check({tag, "_first_valid_lat"}, 64'(first_vld_cyc - start_cyc + 1), 64'd2);
            check({tag, "_done_lat"}, 64'(done_cyc - start_cyc + 1), 64'd33);
        end
        rdy_random = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.key     = '0;
        bus.decrypt = 1'b0;
        #12;
        check("rst_valid", 64'(bus.subkey_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_round", 64'(bus.round), 64'd0);
        check("rst_subkey", 64'(bus.subkey), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        push_enc();
        run("enc", TKEY, 1'b0, 1'b0, 1'b0, 1'b1);

        push_dec();
        run("dec", TKEY, 1'b1, 1'b0, 1'b0, 1'b1);

        push_enc();
        run("enc_stall", TKEY, 1'b0, 1'b1, 1'b0, 1'b0);

        push_const(48'h0);
        run("key_zero", 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        push_const(48'hFFFFFFFFFFFF);
        run("key_ones", 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);

        push_const(48'h0);
        run("key_parity", 64'h0101010101010101, 1'b0, 1'b0, 1'b0, 1'b0);

        push_enc();
        run("disturb", TKEY, 1'b0, 1'b0, 1'b1, 1'b1);

        // Abort after the fifth accepted beat.
        push_enc();
        launch(TKEY, 1'b0, 1'b0);
        n = 0;
        while (beat_cnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (beat_cnt < 5) fail_now("abort_wait_timeout");
        #2;
        rst = 1'b0;
        #1;
        check("abort_valid", 64'(bus.subkey_valid), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_round", 64'(bus.round), 64'd0);
        check("abort_subkey", 64'(bus.subkey), 64'd0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check("abort_hold_done", 64'(bus.done), 64'd0);
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_idle_busy", 64'(bus.busy), 64'd0);
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);

        push_enc();
        run("restart", TKEY, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
